// File: rtl/rf_pkg.sv
// ============================================================================
//  Module   : rf_pkg
//  Purpose  : Shared constants, pending-state encodings and entry layout for
//             the register-file read-request path.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int NBANK  = 4;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 3;
  localparam int OCID_W = 4;

  // Pending flags are {p1, p2}: bit 1 = src1 still to read, bit 0 = src2.
  localparam logic [1:0] PEND_NONE = 2'b00;
  localparam logic [1:0] PEND_S2   = 2'b01;
  localparam logic [1:0] PEND_S1   = 2'b10;
  localparam logic [1:0] PEND_BOTH = 2'b11;

  // Entry layout from LSB: ocid, conflict, r2, b2, s2v, r1, b1, s1v.
  localparam int OFF_OCID = 0;

  function automatic int off_conf(input int row_w, input int ocid_w);
    return ocid_w + 0 * row_w;
  endfunction

  function automatic int off_r2(input int row_w, input int ocid_w);
    return ocid_w + 1 + 0 * row_w;
  endfunction

  function automatic int off_b2(input int row_w, input int ocid_w);
    return ocid_w + 1 + row_w;
  endfunction

  function automatic int off_s2v(input int row_w, input int ocid_w);
    return ocid_w + 1 + row_w + BANK_W;
  endfunction

  function automatic int off_r1(input int row_w, input int ocid_w);
    return ocid_w + 2 + row_w + BANK_W;
  endfunction

  function automatic int off_b1(input int row_w, input int ocid_w);
    return ocid_w + 2 + 2 * row_w + BANK_W;
  endfunction

  function automatic int off_s1v(input int row_w, input int ocid_w);
    return ocid_w + 2 + 2 * row_w + 2 * BANK_W;
  endfunction

  function automatic int entry_w(input int row_w, input int ocid_w);
    return ocid_w + 3 + 2 * row_w + 2 * BANK_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_req_storage.sv
// ============================================================================
//  Module   : rf_req_storage
//  Purpose  : Generic DEPTH x W register FIFO with occupancy count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_req_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_read_req_fifo.sv
// ============================================================================
//  Module   : rf_read_req_fifo
//  Purpose  : Buffers translated operand-read requests and issues per-bank
//             register-file read strobes, splitting same-bank pairs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_read_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int ROW_W  = 3,
  parameter int NBANK  = 4,
  parameter int OCID_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Valid_RAU_ReqFIFO,
  input  logic                         Src1_Valid,
  input  logic [1:0]                   Src1_Phy_Bank_ID,
  input  logic [ROW_W-1:0]             Src1_Phy_Row_ID,
  input  logic                         Src2_Valid,
  input  logic [1:0]                   Src2_Phy_Bank_ID,
  input  logic [ROW_W-1:0]             Src2_Phy_Row_ID,
  input  logic                         ReqFIFO_2op_EN,
  input  logic [OCID_W-1:0]            OCID_RAU_OC,
  input  logic                         WriteValid,
  input  logic [1:0]                   WriteBank,
  output logic                         Full_ReqFIFO_RAU,
  output logic                         Empty_ReqFIFO,
  output logic [$clog2(DEPTH+1)-1:0]   Count_ReqFIFO,
  output logic                         Reject_ReqFIFO_RAU,
  output logic [NBANK-1:0]             Bank_RdEn,
  output logic [NBANK*ROW_W-1:0]       Bank_RdRow,
  output logic [NBANK*OCID_W-1:0]      Bank_RdOCID,
  output logic [NBANK-1:0]             Bank_RdOpnd
);

  import rf_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int EW     = entry_w(ROW_W, OCID_W);
  localparam int O_CONF = off_conf(ROW_W, OCID_W);
  localparam int O_R2   = off_r2(ROW_W, OCID_W);
  localparam int O_B2   = off_b2(ROW_W, OCID_W);
  localparam int O_S2V  = off_s2v(ROW_W, OCID_W);
  localparam int O_R1   = off_r1(ROW_W, OCID_W);
  localparam int O_B1   = off_b1(ROW_W, OCID_W);
  localparam int O_S1V  = off_s1v(ROW_W, OCID_W);

  logic                 st_full, st_empty, st_pop, accept, conflict_in;
  logic [CNT_W-1:0]     st_count;
  logic [EW-1:0]        din, head;
  logic                 h_s1v, h_s2v, h_conf;
  logic [BANK_W-1:0]    h_b1, h_b2;
  logic [ROW_W-1:0]     h_r1, h_r2;
  logic [OCID_W-1:0]    h_ocid;
  logic [1:0]           pend_q, pend_d, pend_eff, pend_left;
  logic                 live_q, live_d;
  logic                 reject_q, reject_d;
  logic                 go1, go2;

  assign conflict_in = ReqFIFO_2op_EN |
                       (Src1_Valid & Src2_Valid & (Src1_Phy_Bank_ID == Src2_Phy_Bank_ID));
  assign din    = {Src1_Valid, Src1_Phy_Bank_ID, Src1_Phy_Row_ID,
                   Src2_Valid, Src2_Phy_Bank_ID, Src2_Phy_Row_ID,
                   conflict_in, OCID_RAU_OC};
  // Full is taken before any same-cycle pop, so a push at full is dropped.
  assign accept   = Valid_RAU_ReqFIFO & ~st_full & (|OCID_RAU_OC);
  assign reject_d = Valid_RAU_ReqFIFO & ~accept;

  rf_req_storage #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (st_pop),
    .din   (din),
    .dout  (head),
    .count (st_count),
    .full  (st_full),
    .empty (st_empty)
  );

  assign h_ocid = head[OFF_OCID +: OCID_W];
  assign h_conf = head[O_CONF];
  assign h_r2   = head[O_R2 +: ROW_W];
  assign h_b2   = head[O_B2 +: BANK_W];
  assign h_s2v  = head[O_S2V];
  assign h_r1   = head[O_R1 +: ROW_W];
  assign h_b1   = head[O_B1 +: BANK_W];
  assign h_s1v  = head[O_S1V];

  // A head not yet touched takes its flags straight from the entry.
  assign pend_eff  = live_q ? pend_q : {h_s1v, h_s2v};
  assign go1       = ~st_empty & pend_eff[1] & ~(WriteValid & (WriteBank == h_b1));
  assign go2       = ~st_empty & pend_eff[0] & ~(WriteValid & (WriteBank == h_b2))
                     & ~(go1 & h_conf);
  assign pend_left = pend_eff & ~{go1, go2};
  assign st_pop    = ~st_empty & (pend_left == PEND_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= PEND_NONE;
      live_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      live_q   <= live_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    pend_d = pend_q;
    live_d = live_q;
    if (st_pop) begin
      pend_d = PEND_NONE;
      live_d = 1'b0;
    end else if (!st_empty) begin
      pend_d = pend_left;
      live_d = 1'b1;
    end
  end

  always_comb begin
    Bank_RdEn   = '0;
    Bank_RdRow  = '0;
    Bank_RdOCID = '0;
    Bank_RdOpnd = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (go1 && (h_b1 == BANK_W'(b))) begin
        Bank_RdEn[b]                   = 1'b1;
        Bank_RdRow[ROW_W*b +: ROW_W]   = h_r1;
        Bank_RdOCID[OCID_W*b +: OCID_W] = h_ocid;
      end else if (go2 && (h_b2 == BANK_W'(b))) begin
        Bank_RdEn[b]                   = 1'b1;
        Bank_RdRow[ROW_W*b +: ROW_W]   = h_r2;
        Bank_RdOCID[OCID_W*b +: OCID_W] = h_ocid;
        Bank_RdOpnd[b]                 = 1'b1;
      end
    end
  end

  assign Full_ReqFIFO_RAU   = st_full;
  assign Empty_ReqFIFO      = st_empty;
  assign Count_ReqFIFO      = st_count;
  assign Reject_ReqFIFO_RAU = reject_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_read_req_fifo.sv
// ============================================================================
//  Module   : tb_rf_read_req_fifo
//  Purpose  : Directed and randomized self-checking bench for rf_read_req_fifo
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_read_req_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_RAU_ReqFIFO, Src1_Valid, Src2_Valid, ReqFIFO_2op_EN, WriteValid;
  logic [1:0]  Src1_Phy_Bank_ID, Src2_Phy_Bank_ID, WriteBank;
  logic [2:0]  Src1_Phy_Row_ID, Src2_Phy_Row_ID;
  logic [3:0]  OCID_RAU_OC;
  logic        Full_ReqFIFO_RAU, Empty_ReqFIFO, Reject_ReqFIFO_RAU;
  logic [2:0]  Count_ReqFIFO;
  logic [3:0]  Bank_RdEn, Bank_RdOpnd;
  logic [11:0] Bank_RdRow;
  logic [15:0] Bank_RdOCID;

  always #5 clk = ~clk;

  rf_read_req_fifo #(
    .DEPTH (DEPTH), .ROW_W (3), .NBANK (4), .OCID_W (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .Valid_RAU_ReqFIFO  (Valid_RAU_ReqFIFO),
    .Src1_Valid         (Src1_Valid),
    .Src1_Phy_Bank_ID   (Src1_Phy_Bank_ID),
    .Src1_Phy_Row_ID    (Src1_Phy_Row_ID),
    .Src2_Valid         (Src2_Valid),
    .Src2_Phy_Bank_ID   (Src2_Phy_Bank_ID),
    .Src2_Phy_Row_ID    (Src2_Phy_Row_ID),
    .ReqFIFO_2op_EN     (ReqFIFO_2op_EN),
    .OCID_RAU_OC        (OCID_RAU_OC),
    .WriteValid         (WriteValid),
    .WriteBank          (WriteBank),
    .Full_ReqFIFO_RAU   (Full_ReqFIFO_RAU),
    .Empty_ReqFIFO      (Empty_ReqFIFO),
    .Count_ReqFIFO      (Count_ReqFIFO),
    .Reject_ReqFIFO_RAU (Reject_ReqFIFO_RAU),
    .Bank_RdEn          (Bank_RdEn),
    .Bank_RdRow         (Bank_RdRow),
    .Bank_RdOCID        (Bank_RdOCID),
    .Bank_RdOpnd        (Bank_RdOpnd)
  );

  // Reference model: each queued request remembers which operands are still owed.
  typedef struct {
    bit       need1;
    bit [1:0] b1;
    bit [2:0] r1;
    bit       need2;
    bit [1:0] b2;
    bit [2:0] r2;
    bit       same_bank;
    bit [3:0] ocid;
  } req_t;

  req_t q[$];
  bit   rej_m;
  bit   m_g1, m_g2;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  e_en, e_op;
    logic [11:0] e_row;
    logic [15:0] e_oc;
    req_t        h;
    e_en = '0; e_op = '0; e_row = '0; e_oc = '0;
    m_g1 = 1'b0; m_g2 = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      m_g1 = h.need1 && !(WriteValid && WriteBank == h.b1);
      m_g2 = h.need2 && !(WriteValid && WriteBank == h.b2) && !(m_g1 && h.same_bank);
      if (m_g1) begin
        e_en[h.b1] = 1'b1;
        e_row[h.b1*3 +: 3] = h.r1;
        e_oc[h.b1*4 +: 4]  = h.ocid;
      end
      if (m_g2) begin
        e_en[h.b2] = 1'b1;
        e_op[h.b2] = 1'b1;
        e_row[h.b2*3 +: 3] = h.r2;
        e_oc[h.b2*4 +: 4]  = h.ocid;
      end
    end
    chk("rden",   64'(Bank_RdEn),          64'(e_en));
    chk("rdrow",  64'(Bank_RdRow),         64'(e_row));
    chk("rdocid", 64'(Bank_RdOCID),        64'(e_oc));
    chk("rdopnd", 64'(Bank_RdOpnd),        64'(e_op));
    chk("count",  64'(Count_ReqFIFO),      64'(q.size()));
    chk("empty",  64'(Empty_ReqFIFO),      64'(q.size() == 0));
    chk("full",   64'(Full_ReqFIFO_RAU),   64'(q.size() == DEPTH));
    chk("reject", 64'(Reject_ReqFIFO_RAU), 64'(rej_m));
  endtask

  task automatic model_update();
    bit   acc;
    req_t h, n;
    acc = Valid_RAU_ReqFIFO && (q.size() < DEPTH) && (OCID_RAU_OC != 0);
    if (q.size() > 0) begin
      h = q[0];
      if (m_g1) h.need1 = 1'b0;
      if (m_g2) h.need2 = 1'b0;
      if (!h.need1 && !h.need2) void'(q.pop_front());
      else q[0] = h;
    end
    if (acc) begin
      n.need1 = Src1_Valid; n.b1 = Src1_Phy_Bank_ID; n.r1 = Src1_Phy_Row_ID;
      n.need2 = Src2_Valid; n.b2 = Src2_Phy_Bank_ID; n.r2 = Src2_Phy_Row_ID;
      n.same_bank = ReqFIFO_2op_EN ||
                    (Src1_Valid && Src2_Valid && Src1_Phy_Bank_ID == Src2_Phy_Bank_ID);
      n.ocid = OCID_RAU_OC;
      q.push_back(n);
    end
    rej_m = Valid_RAU_ReqFIFO && !acc;
  endtask

  task automatic step(input bit v, input bit s1v, input bit [1:0] b1, input bit [2:0] r1,
                      input bit s2v, input bit [1:0] b2, input bit [2:0] r2,
                      input bit en2, input bit [3:0] oc, input bit wv, input bit [1:0] wb);
    @(negedge clk);
    Valid_RAU_ReqFIFO = v;
    Src1_Valid = s1v; Src1_Phy_Bank_ID = b1; Src1_Phy_Row_ID = r1;
    Src2_Valid = s2v; Src2_Phy_Bank_ID = b2; Src2_Phy_Row_ID = r2;
    ReqFIFO_2op_EN = en2; OCID_RAU_OC = oc;
    WriteValid = wv; WriteBank = wb;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input bit wv, input bit [1:0] wb);
    step(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 1'b0, 4'd0, wv, wb);
  endtask

  task automatic rnd_step(input int push_pct, input int wr_pct);
    bit [3:0] oc;
    oc = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'(1 << $urandom_range(0, 3));
    step($urandom_range(0, 99) < push_pct,
         1'($urandom), 2'($urandom), 3'($urandom),
         1'($urandom), 2'($urandom), 3'($urandom),
         $urandom_range(0, 9) == 0, oc,
         $urandom_range(0, 99) < wr_pct, 2'($urandom));
  endtask

  initial begin
    rst = 1'b0;
    Valid_RAU_ReqFIFO = 0; Src1_Valid = 0; Src2_Valid = 0; ReqFIFO_2op_EN = 0;
    Src1_Phy_Bank_ID = 0; Src2_Phy_Bank_ID = 0; Src1_Phy_Row_ID = 0; Src2_Phy_Row_ID = 0;
    OCID_RAU_OC = 0; WriteValid = 0; WriteBank = 0;
    rej_m = 0;
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Two different banks issue together.
    step(1, 1, 2'd0, 3'd3, 1, 2'd2, 3'd5, 0, 4'b0001, 0, 2'd0);
    idle(0, 2'd0);
    idle(0, 2'd0);

    // Same-bank pair splits over two cycles.
    step(1, 1, 2'd1, 3'd2, 1, 2'd1, 3'd6, 1, 4'b0010, 0, 2'd0);
    idle(0, 2'd0);
    idle(0, 2'd0);
    idle(0, 2'd0);

    // Write port blocks the only operand for three cycles.
    step(1, 1, 2'd3, 3'd1, 0, 2'd0, 3'd0, 0, 4'b0100, 0, 2'd0);
    repeat (3) idle(1, 2'd3);
    idle(0, 2'd0);
    idle(0, 2'd0);

    // Fill while blocked; fifth push is rejected, then drain.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 2'd2, 3'(i), 0, 2'd0, 3'd0, 0, 4'(1 << (i % 4)), 1, 2'd2);
    end
    idle(1, 2'd2);
    repeat (6) idle(0, 2'd0);

    // Zero OCID is rejected; an operand-less request drains silently.
    step(1, 1, 2'd0, 3'd1, 0, 2'd0, 3'd0, 0, 4'b0000, 0, 2'd0);
    step(1, 0, 2'd1, 3'd1, 0, 2'd2, 3'd2, 0, 4'b1000, 0, 2'd0);
    idle(0, 2'd0);
    idle(0, 2'd0);

    // Asynchronous reset in the middle of a split.
    step(1, 1, 2'd1, 3'd4, 1, 2'd1, 3'd7, 0, 4'b0010, 0, 2'd0);
    idle(0, 2'd0);
    @(negedge clk);
    Valid_RAU_ReqFIFO = 0; WriteValid = 0;
    #2 rst = 1'b0;
    #1;
    q.delete();
    rej_m = 0;
    m_g1 = 0; m_g2 = 0;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    idle(0, 2'd0);
    idle(0, 2'd0);

    for (int i = 0; i < 600; i++) rnd_step(50, 20);
    for (int i = 0; i < 600; i++) rnd_step(90, 60);
    for (int i = 0; i < 600; i++) rnd_step(30, 5);
    repeat (12) idle(0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_read_req_fifo.md
Name: rf_read_req_fifo

Overview:
- Sits between the register mapping unit and the four register-file banks.
- Accepts translated read requests per instruction: up to two physical (bank, row) operands plus the one-hot operand-collector ID.
- Buffers them in order and issues per-bank read strobes tagged with OCID and operand select.
- Splits same-bank operand pairs over two cycles and yields any bank the CDB write port claims in the current cycle.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ROW_W, 3, physical row index width.
- NBANK, 4, register-file banks; bank ID width 2, fixed.
- OCID_W, 4, one-hot operand-collector ID width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- Valid_RAU_ReqFIFO  in  1  push request this cycle.
- Src1_Valid  in  1  operand 1 needs a read.
- Src1_Phy_Bank_ID  in  2  operand 1 bank.
- Src1_Phy_Row_ID  in  ROW_W  operand 1 row.
- Src2_Valid  in  1  operand 2 needs a read.
- Src2_Phy_Bank_ID  in  2  operand 2 bank.
- Src2_Phy_Row_ID  in  ROW_W  operand 2 row.
- ReqFIFO_2op_EN  in  1  mapping flags both operands in the same bank.
- OCID_RAU_OC  in  OCID_W  one-hot destination collector.
- WriteValid  in  1  CDB write to the RF this cycle.
- WriteBank  in  2  bank written this cycle.
- Full_ReqFIFO_RAU  out  1  count==DEPTH.
- Empty_ReqFIFO  out  1  count==0.
- Count_ReqFIFO  out  clog2(DEPTH+1)  occupancy.
- Reject_ReqFIFO_RAU  out  1  registered one-cycle pulse: push dropped.
- Bank_RdEn  out  NBANK  per-bank read strobe.
- Bank_RdRow  out  NBANK*ROW_W  bank b row at [ROW_W*b +: ROW_W].
- Bank_RdOCID  out  NBANK*OCID_W  bank b tag at [OCID_W*b +: OCID_W].
- Bank_RdOpnd  out  NBANK  bank b operand select: 0=src1, 1=src2.

Behaviour:
- Reset (async, rst==0): pointers, count, pending flags and Reject cleared immediately. All Bank_* outputs are 0, Empty=1, Full=0, Count=0. Reset is honoured mid-split; any partially issued head is discarded.
- Entry contents: {s1v, b1, r1, s2v, b2, r2, conflict, ocid}. conflict = ReqFIFO_2op_EN OR (Src1_Valid & Src2_Valid & b1==b2).
- Push accepted when Valid & !Full & OCID_RAU_OC!=0.
- If Valid & (Full | OCID==0): nothing stored; Reject pulses in the next cycle.
- Full is evaluated before the same-cycle pop, so a push at full is rejected even when a pop occurs.
- No empty-bypass: a push at edge k is issuable at the earliest in the cycle after edge k.
- Head issue state is a two-bit pending register {p1, p2} with states NONE, BOTH, S1, S2.
  - Loaded from head s1v/s2v when a new head becomes valid.
  - A head with s1v=s2v=0 (NONE) pops after one cycle and issues nothing.
- Per cycle, combinational from head, pending flags, WriteValid and WriteBank:
  - go1 = p1 & !(WriteValid & WriteBank==b1).
  - go2 = p2 & !(WriteValid & WriteBank==b2) & !(go1 & conflict).
  - Src1 has priority.
- Bank_RdEn[b1]=go1 (row r1, tag ocid, opnd 0). Bank_RdEn[b2]=go2 (row r2, tag ocid, opnd 1).
- Non-enabled banks drive row/OCID/opnd = 0.
- Flags clear at the edge for operands issued. Pop occurs when all pending flags are clear after this cycle; the next head's flags load at that same edge.
- Throughput: one entry per cycle when there is no conflict and no write blocking. A conflicting entry takes 2 cycles.
- WriteValid may block indefinitely; flags hold and no pop occurs.
- Pointers wrap modulo DEPTH. Count increments on push only, decrements on pop only, and is unchanged when both occur.
- Instruction payload fields are not carried; they travel to the collector separately.

Decomposition:
- Shared package rf_pkg holds:
  - localparams NBANK=4, BANK_W=2, ROW_W=3, OCID_W=4.
  - Pending-state encodings PEND_NONE/S1/S2/BOTH.
  - Entry field offsets.
- One sub-module: rf_req_storage, a generic DEPTH×W register FIFO (push/pop/count/full/empty).
- Issue logic and pending FSM stay in the top.

Test Plan:
- Push {s1 b0 r3, s2 b2 r5, ocid 0001} into empty FIFO → next cycle RdEn=0101, row[2:0]=3, row[8:6]=5, both tags 0001, opnd=0100; entry pops; Empty=1.
- Push {s1 b1 r2, s2 b1 r6, 2op_EN=1, ocid 0010} → cycle 1 RdEn=0010 opnd 0 row 2; cycle 2 RdEn=0010 opnd 1 row 6; then pop.
- Head {s1 b3 r1} with WriteValid=1, WriteBank=3 for 3 cycles → RdEn=0 during those cycles; read issues in the cycle WriteValid drops; Count holds at 1 until then.
- Push 5 back-to-back entries while bank writes block everything → first 4 accepted, Full=1, 5th gives Reject pulse; Count=4; releasing blocks drains entries in order with correct OCIDs.
- Push with OCID=0000 → Reject pulse, Count unchanged. Push with s1v=s2v=0 → no RdEn, pops after 1 cycle.
- Assert rst low mid-split of a conflict entry → outputs zero asynchronously; after release Empty=1, Count=0, no residual RdEn.
